// File: rtl/spi_serf_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_serf_if : SPI serf pins plus host-side word handshake.            |
// | Optional frm_err member: SPI_SERF_BITCNT_CHK_EN.  Revision: 1.0       |
// +-----------------------------------------------------------------------+
interface spi_serf_if;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic        wrt;
  logic [15:0] rx_data;
  logic        rdy;
`ifdef SPI_SERF_BITCNT_CHK_EN
  logic        frm_err;

  modport master (output SS_n, SCLK, MOSI, tx_data, wrt,
                  input  MISO, rx_data, rdy, frm_err);
  modport slave  (input  SS_n, SCLK, MOSI, tx_data, wrt,
                  output MISO, rx_data, rdy, frm_err);
`else
  modport master (output SS_n, SCLK, MOSI, tx_data, wrt,
                  input  MISO, rx_data, rdy);
  modport slave  (input  SS_n, SCLK, MOSI, tx_data, wrt,
                  output MISO, rx_data, rdy);
`endif
endinterface
`default_nettype wire

// File: rtl/spi_serf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_serf : 16-bit SPI serf, oversampled by clk (SCLK idle high).      |
// | Frame-length check macro: SPI_SERF_BITCNT_CHK_EN.  Revision: 1.0      |
// +-----------------------------------------------------------------------+
module spi_serf (
  input  wire logic   clk,
  input  wire logic   rst_n,
  spi_serf_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        ss_s1, ss_s2, ss_s3;
  logic        sclk_s1, sclk_s2, sclk_s3;
  logic        mosi_s1, mosi_s2;
  logic [1:0]  sync_vld;
  logic        ss_armed;

  logic [15:0] shift_reg;
  logic [15:0] tx_buf;
  logic        sample;
  logic        rise_seen;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_reg;
  logic        rdy_reg;

  logic        sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic        frame_start, frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1    <= 1'b1;
      ss_s2    <= 1'b1;
      ss_s3    <= 1'b1;
      sclk_s1  <= 1'b1;
      sclk_s2  <= 1'b1;
      sclk_s3  <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      sync_vld <= 2'b00;
      ss_armed <= 1'b0;
    end else begin
      ss_s1    <= bus.SS_n;
      ss_s2    <= ss_s1;
      ss_s3    <= ss_s2;
      sclk_s1  <= bus.SCLK;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      mosi_s1  <= bus.MOSI;
      mosi_s2  <= mosi_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      // A frame only starts after SS_n has really been seen high, so a
      // reset released mid-frame waits for the next genuine SS_n fall.
      if (sync_vld[1] && ss_s2)
        ss_armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign ss_fall   = ss_armed & ~ss_s2 & ss_s3;
  assign ss_rise   = ss_s2 & ~ss_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt   = SHIFT;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SPI_SERF_BITCNT_CHK_EN
  logic frm_err_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= 16'h0000;
      tx_buf      <= 16'h0000;
      sample      <= 1'b0;
      rise_seen   <= 1'b0;
      bit_cnt     <= 5'd0;
      rx_reg      <= 16'h0000;
      rdy_reg     <= 1'b0;
`ifdef SPI_SERF_BITCNT_CHK_EN
      frm_err_reg <= 1'b0;
`endif
    end else begin
      rdy_reg <= 1'b0;
      if (bus.wrt)
        tx_buf <= bus.tx_data;

      if (frame_start) begin
        shift_reg <= bus.wrt ? bus.tx_data : tx_buf;
        bit_cnt   <= 5'd0;
        rise_seen <= 1'b0;
`ifdef SPI_SERF_BITCNT_CHK_EN
        frm_err_reg <= 1'b0;
`endif
      end else if ((state == SHIFT) && !frame_end) begin
        if (sclk_rise) begin
          sample    <= mosi_s2;
          rise_seen <= 1'b1;
          if (bit_cnt != 5'd16)
            bit_cnt <= bit_cnt + 5'd1;
        end
        // The leading fall precedes any rise and must not shift.
        if (sclk_fall && rise_seen)
          shift_reg <= {shift_reg[14:0], sample};
      end

      // The last bit is sampled on the final rise but never shifted in.
      if (frame_end) begin
`ifdef SPI_SERF_BITCNT_CHK_EN
        if (bit_cnt == 5'd16) begin
          rx_reg  <= {shift_reg[14:0], sample};
          rdy_reg <= 1'b1;
        end else begin
          frm_err_reg <= 1'b1;
        end
`else
        rx_reg  <= {shift_reg[14:0], sample};
        rdy_reg <= 1'b1;
`endif
      end
    end
  end

  assign bus.MISO    = (state == SHIFT) ? shift_reg[15] : 1'b0;
  assign bus.rx_data = rx_reg;
  assign bus.rdy     = rdy_reg;
`ifdef SPI_SERF_BITCNT_CHK_EN
  assign bus.frm_err = frm_err_reg;
`endif

endmodule
`default_nettype wire

// File: doc/spi_serf.md
SPI_SERF -- requirements
Module: spi_serf

Interface
REQ-001 The interface SHALL have one clock and an asynchronous active-low reset. Clock port: clk. Reset port: rst_n.
REQ-002 Port list SHALL be:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- SS_n, input, 1: serial select from the monarch; active low; asynchronous to clk.
- SCLK, input, 1: serial clock from the monarch; asynchronous to clk.
- MOSI, input, 1: serial data from the monarch, MSB first.
- MISO, output, 1: serial data to the monarch, MSB first.
- tx_data, input, 16: response word for the next frame.
- wrt, input, 1: one-cycle pulse that loads tx_data into the transmit buffer.
- rx_data, output, 16: last completed received word.
- rdy, output, 1: one-cycle pulse when rx_data has just been updated.
- frm_err, output, 1: framing error flag; exists only when SPI_SERF_BITCNT_CHK_EN is defined.

Function
REQ-003 SS_n, SCLK and MOSI SHALL each pass through a 2-flop metastability synchronizer of identical depth; a third SS_n flop and a third SCLK flop SHALL provide edge detection.
REQ-004 SCLK rise SHALL be detected as sync2 high and flop3 low; SCLK fall as sync2 low and flop3 high; the same rule applies to SS_n fall and SS_n rise.
REQ-005 On a detected SCLK rise, the synchronized MOSI (sync2, same cycle) SHALL be captured into a 1-bit sample register.
REQ-006 On a detected SCLK fall, and only when at least one rise has occurred in the current frame, shift_reg SHALL update to {shift_reg[14:0], sample}.
REQ-007 The leading SCLK fall, which precedes the first rise, SHALL be ignored.
REQ-008 MISO SHALL equal shift_reg[15] while the FSM is in SHIFT; otherwise MISO SHALL be 0.
REQ-009 The transmit buffer SHALL load tx_data on wrt. wrt received mid-frame SHALL update only the buffer, never shift_reg.
REQ-010 The FSM SHALL have 2 states, IDLE and SHIFT:
- IDLE to SHIFT on SS_n fall. In that cycle shift_reg loads the transmit buffer, the bit counter clears, and the rise-seen flag clears.
- SHIFT to IDLE on SS_n rise.
REQ-011 If wrt coincides with SS_n fall, tx_data SHALL bypass the buffer and load shift_reg directly.
REQ-012 The bit counter SHALL be 5 bits, increment on each detected rise in SHIFT, and saturate at 16.
REQ-013 On SS_n rise with 16 bits captured, the following SHALL happen in the same cycle:
- rx_data takes {shift_reg[14:0], sample}, which includes the final bit sampled but not shifted.
- rdy pulses for exactly one cycle.
REQ-014 rx_data SHALL hold its value until the next completed frame.
REQ-015 Edges of SCLK and MOSI SHALL be ignored while in IDLE.
REQ-016 A frame completion in the same cycle as wrt SHALL perform both actions independently.

Reset
REQ-017 rst_n low SHALL asynchronously force the following, aborting any frame in progress:
- FSM to IDLE;
- all synchronizer flops to the idle levels SS_n=1, SCLK=1, MOSI=0;
- shift_reg, buffer, sample, counter, rx_data to 0;
- rdy=0, MISO=0, frm_err=0.
REQ-018 After reset release mid-frame, the block SHALL wait for a fresh SS_n fall; the SS_n rise of the aborted frame SHALL not produce rdy.

Configuration
REQ-019 Macro SPI_SERF_BITCNT_CHK_EN defined: the frame-length check SHALL be compiled in.
- SS_n rise with bit count other than 16: rdy stays low, rx_data is unchanged, frm_err is set.
- frm_err stays set until the next SS_n fall, which clears it.
REQ-020 Macro SPI_SERF_BITCNT_CHK_EN undefined: the frm_err port and the check SHALL be absent, and every SS_n rise in SHIFT SHALL update rx_data and pulse rdy, regardless of bit count.

Verification
REQ-021 The bench SHALL cover these directed scenarios (SCLK half-period 16 clk):
- Reset, then wrt with tx_data=0xA5C3; monarch sends 0x1234 -> monarch receives 0xA5C3; rx_data=0x1234; one rdy pulse about 2-3 clk after SS_n rise.
- Back-to-back frames 0xFFFF then 0x0001, with wrt=0x8000 between them -> rx_data sequence 0xFFFF then 0x0001; second MISO word 0x8000.
- wrt=0x5555 in the same cycle as SS_n fall -> MISO carries 0x5555.
- 8-bit frame aborted by SS_n rise:
  - macro defined: no rdy, frm_err=1, rx_data unchanged;
  - macro undefined: rdy pulses.
- rst_n asserted after 7 bits -> MISO=0, FSM IDLE, no rdy at the later SS_n rise; the next full frame 0xBEEF is received correctly.
- SCLK toggling with SS_n high -> no shift, no rdy, MISO=0.
